cwe1262_lock_reader: RTL and testbench

Read-side agent for a multi-entry secure register array. It serves single-beat read requests over a valid/ready request channel and a valid/ready response channel. A single sticky lock gates every array entry uniformly, so no entry is readable once the lock is set. Denied accesses are counted for debug and status visibility.

---
 rtl/cwe1262_lock_reader_if.sv | 24 ++
 rtl/cwe1262_lock_reader.sv | 108 ++++++++++
 tb/tb_cwe1262_lock_reader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cwe1262_lock_reader_if.sv
// Request/response handshake bundle for the lock-gated register reader.
// The requester uses master and the reader uses slave. Both channels are valid/ready.
interface cwe1262_lock_reader_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/cwe1262_lock_reader.sv
// Single-beat reader for a register array behind one sticky lock. The response is valid 1 cycle after accept.
// Backpressure: a held response keeps req_ready low and freezes its data and error, so throughput is one read per 2 cycles.
module cwe1262_lock_reader #(
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 2,
  parameter int ADDR_W    = 2,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_flat,
  input  logic                        lock_set,
  cwe1262_lock_reader_if.slave        bus,
  output logic                        locked,
  output logic [CNT_W-1:0]            deny_cnt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

  localparam logic [ADDR_W:0] NUM_BANKS_W = (ADDR_W + 1)'(NUM_BANKS);

  state_e            state_q, state_d;
  logic              locked_q, locked_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  deny_cnt_q, deny_cnt_d;

  logic              accept;
  logic              lock_eff;
  logic              in_range;
  logic              deny;
  logic [DATA_W-1:0] entry_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req_valid) state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = rst_n && (state_q == S_IDLE);
    bus.rsp_valid = (state_q == S_RESP);
  end

  assign accept   = bus.req_valid && bus.req_ready;
  // A lock arriving in the same cycle as the accept must already deny it.
  assign lock_eff = locked_q | lock_set;
  assign in_range = {1'b0, bus.req_addr} < NUM_BANKS_W;
  assign deny     = lock_eff | ~in_range;

  // Compare-and-select mux: an out-of-range index matches no entry and never reaches bank_flat.
  always_comb begin
    entry_sel = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bus.req_addr == ADDR_W'(i)) begin
        entry_sel = bank_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    locked_d   = locked_q | lock_set;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    deny_cnt_d = deny_cnt_q;
    if (accept) begin
      rsp_err_d  = deny;
      rsp_data_d = deny ? '0 : entry_sel;
      if (deny && (deny_cnt_q != {CNT_W{1'b1}})) begin
        deny_cnt_d = deny_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      locked_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      deny_cnt_q <= '0;
    end else begin
      locked_q   <= locked_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      deny_cnt_q <= deny_cnt_d;
    end
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;
  assign locked       = locked_q;
  assign deny_cnt     = deny_cnt_q;

endmodule

// File: tb/tb_cwe1262_lock_reader.sv
// Bench for cwe1262_lock_reader. DUT A uses the default parameters; DUT B uses NUM_BANKS=3 with a 2-bit counter.
// Inputs are driven on the falling edge and outputs are sampled there. Expected values come from a small transaction model.
module tb_cwe1262_lock_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] bank_v [2];
  logic       lk_v   [2];
  logic       vld_v  [2];
  logic       rdy_v  [2];
  logic [1:0] addr_v [2];

  logic       a_locked, b_locked;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;

  cwe1262_lock_reader_if #(.ADDR_W(2), .DATA_W(2)) a_if ();
  cwe1262_lock_reader_if #(.ADDR_W(2), .DATA_W(2)) b_if ();

  assign a_if.req_valid = vld_v[0];
  assign a_if.req_addr  = addr_v[0];
  assign a_if.rsp_ready = rdy_v[0];
  assign b_if.req_valid = vld_v[1];
  assign b_if.req_addr  = addr_v[1];
  assign b_if.rsp_ready = rdy_v[1];

  cwe1262_lock_reader #(.NUM_BANKS(4), .DATA_W(2), .ADDR_W(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bank_flat(bank_v[0]), .lock_set(lk_v[0]),
    .bus(a_if), .locked(a_locked), .deny_cnt(a_cnt)
  );

  cwe1262_lock_reader #(.NUM_BANKS(3), .DATA_W(2), .ADDR_W(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bank_flat(bank_v[1][5:0]), .lock_set(lk_v[1]),
    .bus(b_if), .locked(b_locked), .deny_cnt(b_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: lock flag, deny count, counter ceiling and entry count per DUT.
  bit m_locked [2];
  int m_cnt    [2];
  int m_max    [2] = '{255, 3};
  int m_nb     [2] = '{4, 3};

  task automatic sample(input bit b, output logic v, output logic rr, output logic [1:0] d,
                        output logic e, output logic lk, output logic [7:0] c);
    if (b) begin
      v = b_if.rsp_valid; rr = b_if.req_ready; d = b_if.rsp_data; e = b_if.rsp_err;
      lk = b_locked; c = {6'b0, b_cnt};
    end else begin
      v = a_if.rsp_valid; rr = a_if.req_ready; d = a_if.rsp_data; e = a_if.rsp_err;
      lk = a_locked; c = a_cnt;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vld_v[i] = 1'b0; lk_v[i] = 1'b0; rdy_v[i] = 1'b0; addr_v[i] = 2'd0;
      m_locked[i] = 1'b0; m_cnt[i] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_lock(input bit b);
    lk_v[b] = 1'b1;
    m_locked[b] = 1'b1;
    @(negedge clk);
    lk_v[b] = 1'b0;
  endtask

  // One read transaction: accept, hold the response for 'hold' extra cycles, then complete it.
  task automatic do_read(input bit b, input logic [1:0] addr, input bit lk, input int hold,
                         input bit tog, input string nm);
    logic v, rr, e, lko;
    logic [1:0] d;
    logic [7:0] c;
    logic [1:0] exp_d;
    logic [7:0] shifted;
    bit exp_e;
    sample(b, v, rr, d, e, lko, c);
    n_checks++;
    if (rr !== 1'b1) begin n_fail++; $display("FAIL %s idle_req_ready got %b want 1", nm, rr); end
    exp_e = m_locked[b] || lk || (int'(addr) >= m_nb[b]);
    shifted = bank_v[b] >> (2 * int'(addr));
    exp_d = exp_e ? 2'b00 : shifted[1:0];
    if (exp_e && m_cnt[b] < m_max[b]) m_cnt[b]++;
    if (lk) m_locked[b] = 1'b1;
    vld_v[b] = 1'b1; addr_v[b] = addr; lk_v[b] = lk; rdy_v[b] = 1'b0;
    @(negedge clk);
    vld_v[b] = 1'b0; lk_v[b] = 1'b0; addr_v[b] = 2'($urandom_range(0, 3));
    for (int k = 0; k <= hold; k++) begin
      sample(b, v, rr, d, e, lko, c);
      n_checks++;
      if (v !== 1'b1) begin n_fail++; $display("FAIL %s rsp_valid[%0d] got %b want 1", nm, k, v); end
      n_checks++;
      if (rr !== 1'b0) begin n_fail++; $display("FAIL %s busy_req_ready[%0d] got %b want 0", nm, k, rr); end
      n_checks++;
      if (d !== exp_d) begin n_fail++; $display("FAIL %s rsp_data[%0d] got %b want %b", nm, k, d, exp_d); end
      n_checks++;
      if (e !== exp_e) begin n_fail++; $display("FAIL %s rsp_err[%0d] got %b want %b", nm, k, e, exp_e); end
      n_checks++;
      if (lko !== m_locked[b]) begin n_fail++; $display("FAIL %s locked[%0d] got %b want %b", nm, k, lko, m_locked[b]); end
      n_checks++;
      if (c !== 8'(m_cnt[b])) begin n_fail++; $display("FAIL %s deny_cnt[%0d] got %0d want %0d", nm, k, c, m_cnt[b]); end
      if (k == hold) begin
        rdy_v[b] = 1'b1;
      end else begin
        bank_v[b] = 8'($urandom);
        if (tog) begin
          lk_v[b] = 1'($urandom);
          if (lk_v[b]) m_locked[b] = 1'b1;
        end
      end
      @(negedge clk);
      lk_v[b] = 1'b0;
    end
    rdy_v[b] = 1'b0;
    sample(b, v, rr, d, e, lko, c);
    n_checks++;
    if (v !== 1'b0) begin n_fail++; $display("FAIL %s done_rsp_valid got %b want 0", nm, v); end
    n_checks++;
    if (rr !== 1'b1) begin n_fail++; $display("FAIL %s done_req_ready got %b want 1", nm, rr); end
  endtask

  task automatic test_reset();
    logic v, rr, e, lko;
    logic [1:0] d;
    logic [7:0] c;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vld_v[i] = 1'b1; lk_v[i] = 1'b0; rdy_v[i] = 1'b0; addr_v[i] = 2'd0; bank_v[i] = 8'hE4;
    end
    @(negedge clk);
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      sample(1'(b), v, rr, d, e, lko, c);
      n_checks++;
      if (rr !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready dut%0d got %b want 0", b, rr); end
      n_checks++;
      if (v !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid dut%0d got %b want 0", b, v); end
      n_checks++;
      if ({d, e} !== 3'b000) begin n_fail++; $display("FAIL reset_rsp dut%0d got data %b err %b want 0", b, d, e); end
      n_checks++;
      if (lko !== 1'b0) begin n_fail++; $display("FAIL reset_locked dut%0d got %b want 0", b, lko); end
      n_checks++;
      if (c !== 8'd0) begin n_fail++; $display("FAIL reset_deny_cnt dut%0d got %0d want 0", b, c); end
    end
    vld_v[0] = 1'b0; vld_v[1] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin m_locked[i] = 1'b0; m_cnt[i] = 0; end
  endtask

  task automatic test_basic_read();
    apply_reset();
    bank_v[0] = 8'b11_10_01_00;
    do_read(1'b0, 2'd2, 1'b0, 0, 1'b0, "basic_addr2");
  endtask

  task automatic test_lock_all();
    apply_reset();
    bank_v[0] = 8'b11_10_01_00;
    pulse_lock(1'b0);
    for (int a = 0; a < 4; a++) do_read(1'b0, 2'(a), 1'b0, 0, 1'b0, "locked_read");
    n_checks++;
    if (a_cnt !== 8'd4) begin n_fail++; $display("FAIL lock_all_cnt got %0d want 4", a_cnt); end
  endtask

  task automatic test_same_cycle_lock();
    apply_reset();
    bank_v[0] = 8'b11_10_01_00;
    do_read(1'b0, 2'd1, 1'b0, 0, 1'b0, "pre_lock_addr1");
    do_read(1'b0, 2'd1, 1'b1, 0, 1'b0, "same_cycle_lock");
    n_checks++;
    if (a_cnt !== 8'd1) begin n_fail++; $display("FAIL same_cycle_cnt got %0d want 1", a_cnt); end
  endtask

  task automatic test_hold();
    apply_reset();
    bank_v[0] = 8'b11_10_01_00;
    do_read(1'b0, 2'd3, 1'b0, 5, 1'b0, "hold_bank");
    do_read(1'b0, 2'd0, 1'b0, 5, 1'b1, "hold_bank_lock");
  endtask

  task automatic test_range_saturate();
    apply_reset();
    bank_v[1] = 8'b00_10_01_11;
    do_read(1'b1, 2'd2, 1'b0, 0, 1'b0, "range_last_valid");
    do_read(1'b1, 2'd3, 1'b0, 0, 1'b0, "range_addr3");
    do_read(1'b1, 2'd3, 1'b0, 1, 1'b0, "range_addr3_again");
    pulse_lock(1'b1);
    for (int a = 0; a < 3; a++) do_read(1'b1, 2'(a), 1'b0, 0, 1'b0, "saturate");
    n_checks++;
    if (b_cnt !== 2'd3) begin n_fail++; $display("FAIL saturate_cnt got %0d want 3", b_cnt); end
  endtask

  task automatic test_reset_in_resp();
    logic v, rr, e, lko;
    logic [1:0] d;
    logic [7:0] c;
    apply_reset();
    bank_v[0] = 8'b11_10_01_00;
    pulse_lock(1'b0);
    do_read(1'b0, 2'd1, 1'b0, 0, 1'b0, "pre_reset_denied");
    vld_v[0] = 1'b1; addr_v[0] = 2'd2;
    @(negedge clk);
    vld_v[0] = 1'b0;
    sample(1'b0, v, rr, d, e, lko, c);
    n_checks++;
    if (v !== 1'b1) begin n_fail++; $display("FAIL rir_in_resp got %b want 1", v); end
    rst_n = 1'b0;
    @(negedge clk);
    sample(1'b0, v, rr, d, e, lko, c);
    n_checks++;
    if (v !== 1'b0) begin n_fail++; $display("FAIL rir_rsp_valid got %b want 0", v); end
    n_checks++;
    if (lko !== 1'b0) begin n_fail++; $display("FAIL rir_locked got %b want 0", lko); end
    n_checks++;
    if (c !== 8'd0) begin n_fail++; $display("FAIL rir_deny_cnt got %0d want 0", c); end
    n_checks++;
    if (rr !== 1'b0) begin n_fail++; $display("FAIL rir_req_ready_in_reset got %b want 0", rr); end
    rst_n = 1'b1;
    m_locked[0] = 1'b0; m_cnt[0] = 0; m_locked[1] = 1'b0; m_cnt[1] = 0;
    @(negedge clk);
    do_read(1'b0, 2'd0, 1'b0, 0, 1'b0, "post_reset_addr0");
  endtask

  task automatic test_random();
    bit b;
    apply_reset();
    for (int it = 0; it < 80; it++) begin
      if (it % 20 == 19) apply_reset();
      b = 1'($urandom);
      bank_v[b] = 8'($urandom);
      do_read(b, 2'($urandom_range(0, 3)), ($urandom_range(0, 11) == 0), $urandom_range(0, 3),
              1'b0, "random");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_read();
    test_lock_all();
    test_same_cycle_lock();
    test_hold();
    test_range_saturate();
    test_reset_in_resp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
